// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT sequencer: FSM state codes and the
// per-stage butterfly partner mask.
package fft_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Mask with the top s bits of an aw-bit bank address set; XOR with it
    // gives the butterfly partner address in the other bank pair.
    function automatic logic [31:0] stage_mask(input int aw, input int s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < aw && i >= aw - s) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_delay.sv
// Shift register carrying read-time control fields to the write side.
// Flush clears only the valid bits; data is qualified by valid downstream.
module ctrl_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    logic [DEPTH-1:0] vld_sr;
    logic [WIDTH-1:0] data_sr [DEPTH];

    // Valid chain, cleared in one cycle by flush.
    always_ff @(posedge clk) begin
        if (flush) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= vld_in;
            for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Data chain, free-running with no reset.
    always_ff @(posedge clk) begin
        data_sr[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) data_sr[i] <= data_sr[i-1];
    end

    assign vld_out  = vld_sr[DEPTH-1];
    assign data_out = data_sr[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Stage/address sequencer for the in-place radix-2 FFT engine of size
// 2^LOG2N. Generates bank read addresses, twiddle addresses, crossbar
// selects and PE-latency-aligned write controls, with start/abort handshake.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N    = 8,
    parameter int PIPE_LAT = 2,
    parameter int RD_LAT   = 1,
    localparam int AW      = LOG2N - 2,
    localparam int NSTG    = LOG2N - 1,
    localparam int SW      = $clog2(LOG2N - 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic [AW-1:0] rd_addr0,
    output logic [AW-1:0] rd_addr1,
    output logic          rd_swap,
    output logic [AW-1:0] tf_addr,
    output logic          bypass,
    output logic [3:0]    wr_en,
    output logic [AW-1:0] wr_addr0,
    output logic [AW-1:0] wr_addr1,
    output logic          wr_swap
);

    localparam int DLY = RD_LAT + PIPE_LAT;
    localparam int DW  = 2 * AW + 1;

    // c keeps counting through DRAIN; its extra top bit keeps the drain
    // count clear of the address range.
    localparam logic [AW:0]   C_RUN_LAST   = (AW+1)'((1 << AW) - 1);
    localparam logic [AW:0]   C_DRAIN_LAST = (AW+1)'((1 << AW) + DLY - 1);
    localparam logic [SW-1:0] S_LAST       = SW'(NSTG - 1);

    logic [1:0]    state;
    logic [AW:0]   c;
    logic [SW-1:0] s;
    logic          run;
    logic          active;
    logic [AW-1:0] ca;
    logic [31:0]   mask_full;
    logic [AW-1:0] mask;
    logic [AW-1:0] rsh;
    logic [AW:0]   wsh;
    logic [DW-1:0] dly_in;
    logic [DW-1:0] dly_out;
    logic          dly_vld;

    // Sequencer FSM; reset and abort both drop straight back to idle.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state <= ST_IDLE;
            c     <= '0;
            s     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        c     <= '0;
                        s     <= '0;
                    end
                end
                ST_RUN: begin
                    c <= c + {{AW{1'b0}}, 1'b1};
                    if (c == C_RUN_LAST) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (c == C_DRAIN_LAST) begin
                        c <= '0;
                        if (s == S_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            s     <= s + {{(SW-1){1'b0}}, 1'b1};
                            state <= ST_RUN;
                        end
                    end else begin
                        c <= c + {{AW{1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    s     <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign run       = (state == ST_RUN);
    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign ca        = c[AW-1:0];
    assign mask_full = stage_mask(AW, int'(s));
    assign mask      = mask_full[AW-1:0];

    // rsh[0] = c[AW-s] (zero at s=0); wsh[0] = c[AW-1-s] (zero at s=AW).
    assign rsh = ca >> (AW - int'(s));
    assign wsh = {ca, 1'b0} >> (AW - int'(s));

    assign busy     = active;
    assign done     = (state == ST_DONE);
    assign stage    = s;
    assign bypass   = active && (s == S_LAST);
    assign rd_addr0 = run ? ca : '0;
    assign rd_addr1 = run ? (ca ^ mask) : '0;
    assign rd_swap  = run & rsh[0];
    assign tf_addr  = run ? AW'(ca << s) : '0;

    assign dly_in = {ca, ca ^ mask, wsh[0]};

    ctrl_delay #(
        .DEPTH (DLY),
        .WIDTH (DW)
    ) u_delay (
        .clk      (clk),
        .flush    (reset | abort),
        .vld_in   (run),
        .data_in  (dly_in),
        .vld_out  (dly_vld),
        .data_out (dly_out)
    );

    assign wr_en    = {4{dly_vld}};
    assign wr_addr0 = dly_vld ? dly_out[DW-1:AW+1] : '0;
    assign wr_addr1 = dly_vld ? dly_out[AW:1] : '0;
    assign wr_swap  = dly_vld & dly_out[0];

endmodule
